ped_request_conditioner: RTL and testbench

Upstream input stage for the traffic-light controller. Conditions a raw pedestrian push-button: synchronises it, debounces it on the slow timing tick, and turns each press into a level request held until the controller acknowledges it. Also keeps a saturating press counter for debug display on the bidirectional pins.

---
 rtl/ped_pkg.sv | 18 +
 rtl/ped_debounce.sv | 64 ++++++
 rtl/ped_request_conditioner.sv | 127 ++++++++++++
 tb/tb_ped_request_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian request conditioner.
package ped_pkg;

  localparam int DCNT_W = 4;
  localparam int LCNT_W = 6;
  localparam logic [7:0] PRESS_CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_REL = 2'd2
  } req_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == PRESS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button synchroniser plus tick-sampled debouncer; also reused for the Start input.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_clean_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ped_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_bad_db
    $error("ped_debounce: DEBOUNCE_TICKS must be in 1..15");
  end

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic                   clean_q, clean_d;
  logic                   btn_sync;

  assign btn_sync    = sync_q[SYNC_STAGES-1];
  assign btn_clean_o = clean_q;

  always_comb begin
    sync_d  = sync_q;
    dcnt_d  = dcnt_q;
    clean_d = clean_q;
    if (ena) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
      if (tick) begin
        if (btn_sync == clean_q) begin
          dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          clean_d = btn_sync;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dcnt_q  <= dcnt_d;
      clean_q <= clean_d;
    end
  end

endmodule

// File: rtl/ped_request_conditioner.sv
// Pedestrian button conditioner: debounce, level request with ack handshake, press counter.
// Optional long-press pulse is built when PED_LONG_PRESS_EN is defined.
//
// state    | meaning
// IDLE     | no request pending, waiting for a new press
// REQ      | request pending (req_o = 1), further presses merged
// WAIT_REL | acknowledged, waiting for the button to be released
module ped_request_conditioner
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tick,
  input  logic       btn_raw,
  input  logic       ack_i,
  output logic       req_o,
  output logic       btn_clean_o,
  output logic [7:0] press_cnt_o,
  output logic       long_o
);

  if (LONG_TICKS < 1 || LONG_TICKS > 63) begin : g_bad_long
    $error("ped_request_conditioner: LONG_TICKS must be in 1..63");
  end

  logic       btn_clean;
  logic       clean_prev_q, clean_prev_d;
  logic       press_pulse;
  req_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  ped_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tick       (tick),
    .btn_raw    (btn_raw),
    .btn_clean_o(btn_clean)
  );

  assign btn_clean_o = btn_clean;
  assign press_cnt_o = cnt_q;
  assign press_pulse = btn_clean & ~clean_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clean_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clean_prev_q <= clean_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clean_prev_d = clean_prev_q;
    if (ena) begin
      clean_prev_d = btn_clean;
      case (state_q)
        IDLE: begin
          // an ack arriving with the press is not applied in the same cycle
          if (press_pulse) begin
            state_d = REQ;
            cnt_d   = sat_inc8(cnt_q);
          end
        end
        REQ:      if (ack_i) state_d = WAIT_REL;
        WAIT_REL: if (!btn_clean) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_o = (state_q == REQ);
  end

`ifdef PED_LONG_PRESS_EN
  localparam logic [LCNT_W-1:0] LONG_MAX  = LCNT_W'(LONG_TICKS);
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_TICKS - 1);

  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              long_q, long_d;

  always_comb begin
    lcnt_d = lcnt_q;
    long_d = long_q;
    if (ena) begin
      long_d = 1'b0;
      if (!btn_clean) begin
        lcnt_d = '0;
      end else if (tick && lcnt_q != LONG_MAX) begin
        // saturation at LONG_MAX is what limits this to one pulse per hold
        lcnt_d = lcnt_q + 1'b1;
        long_d = (lcnt_q == LONG_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: behavioural model compared every cycle, plus literal checks.
module tb_ped_request_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 20;
`ifdef PED_LONG_PRESS_EN
  localparam int LONG_EXP = 1;
`else
  localparam int LONG_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       tick = 1'b0;
  logic       btn_raw = 1'b0;
  logic       ack_i = 1'b0;
  logic       req_o;
  logic       btn_clean_o;
  logic [7:0] press_cnt_o;
  logic       long_o;

  int n_cmp = 0;
  int n_bad = 0;

  ped_request_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LONG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .btn_raw(btn_raw),
    .ack_i(ack_i), .req_o(req_o), .btn_clean_o(btn_clean_o),
    .press_cnt_o(press_cnt_o), .long_o(long_o)
  );

  always #5 clk = ~clk;

  // tick: one clk high every three clks
  initial begin
    forever begin
      repeat (2) @(posedge clk);
      #2 tick = 1'b1;
      @(posedge clk);
      #2 tick = 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  int  m_pipe[SYNC];        // samples of btn_raw, [SYNC-1] is the oldest
  int  m_run;               // consecutive differing ticks seen
  bit  m_clean, m_prev, m_pending, m_held, m_long;
  int  m_cnt, m_lticks;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
      m_run = 0; m_clean = 0; m_prev = 0; m_pending = 0; m_held = 0;
      m_cnt = 0; m_lticks = 0; m_long = 0;
    end else if (ena) begin
      bit old_clean, sync_now, rose;
      old_clean = m_clean;
      sync_now  = (m_pipe[SYNC-1] != 0);
      rose      = old_clean && !m_prev;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = int'(btn_raw);
      if (tick) begin
        if (sync_now == old_clean) m_run = 0;
        else if (m_run + 1 >= DB) begin m_clean = sync_now; m_run = 0; end
        else m_run = m_run + 1;
      end
      if (m_pending) begin
        if (ack_i) begin m_pending = 0; m_held = 1; end
      end else if (m_held) begin
        if (!old_clean) m_held = 0;
      end else if (rose) begin
        m_pending = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_prev = old_clean;
      m_long = 0;
      if (!old_clean) m_lticks = 0;
      else if (tick && m_lticks < LONG) begin
        m_lticks = m_lticks + 1;
        m_long = (LONG_EXP == 1) && (m_lticks == LONG);
      end
    end
  end

  always @(negedge clk) begin
    n_cmp += 4;
    if (req_o !== m_pending) begin
      n_bad++; $display("FAIL model_req: got %b want %b at %0t", req_o, m_pending, $time);
    end
    if (btn_clean_o !== m_clean) begin
      n_bad++; $display("FAIL model_clean: got %b want %b at %0t", btn_clean_o, m_clean, $time);
    end
    if (press_cnt_o !== 8'(m_cnt)) begin
      n_bad++; $display("FAIL model_cnt: got %0d want %0d at %0t", press_cnt_o, m_cnt, $time);
    end
    if (long_o !== m_long) begin
      n_bad++; $display("FAIL model_long: got %b want %b at %0t", long_o, m_long, $time);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    #2;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #2 ack_i = 1'b1;
    @(posedge clk); #2 ack_i = 1'b0;
  endtask

  int long_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", int'(req_o), 0);
    check("reset_clean", int'(btn_clean_o), 0);
    check("reset_cnt", int'(press_cnt_o), 0);
    check("reset_long", int'(long_o), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // glitch shorter than the debounce window
    btn_raw = 1'b1; wait_ticks(3);
    btn_raw = 1'b0; wait_ticks(8);
    check("glitch_clean", int'(btn_clean_o), 0);
    check("glitch_req", int'(req_o), 0);
    check("glitch_cnt", int'(press_cnt_o), 0);

    // first real press
    btn_raw = 1'b1; wait_ticks(10);
    check("press_clean", int'(btn_clean_o), 1);
    check("press_req", int'(req_o), 1);
    check("press_cnt", int'(press_cnt_o), 1);

    // ack while still held: request drops, no re-request
    pulse_ack(); #1;
    check("ack_req_drop", int'(req_o), 0);
    wait_ticks(6);
    check("held_no_rereq", int'(req_o), 0);
    btn_raw = 1'b0; wait_ticks(8);
    btn_raw = 1'b1; wait_ticks(8);
    check("second_req", int'(req_o), 1);
    check("second_cnt", int'(press_cnt_o), 2);

    // merged presses while pending
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b0; wait_ticks(8);
      btn_raw = 1'b1; wait_ticks(8);
    end
    check("merge_req", int'(req_o), 1);
    check("merge_cnt", int'(press_cnt_o), 2);
    pulse_ack();
    btn_raw = 1'b0; wait_ticks(8);
    check("released_req", int'(req_o), 0);

    // ack in IDLE is ignored
    pulse_ack(); repeat (3) @(posedge clk); #2;
    check("idle_ack_req", int'(req_o), 0);
    check("idle_ack_cnt", int'(press_cnt_o), 2);

    // ena low freezes everything, including the synchroniser
    ena = 1'b0; btn_raw = 1'b1; wait_ticks(10);
    check("frozen_clean", int'(btn_clean_o), 0);
    check("frozen_req", int'(req_o), 0);
    ena = 1'b1; wait_ticks(8);
    check("resume_clean", int'(btn_clean_o), 1);
    check("resume_cnt", int'(press_cnt_o), 3);
    pulse_ack();
    btn_raw = 1'b0; wait_ticks(8);

    // long press: hold well past LONG ticks, count pulses
    long_seen = 0;
    btn_raw = 1'b1;
    for (int t = 0; t < 3 * 40; t++) begin
      @(negedge clk);
      if (long_o) long_seen++;
    end
    #2;
    check("long_pulses", long_seen, LONG_EXP);
    pulse_ack();
    btn_raw = 1'b0; wait_ticks(8);
    check("after_long_cnt", int'(press_cnt_o), 4);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(19) == 0) btn_raw = ~btn_raw;
      ack_i = ($urandom_range(7) == 0);
      ena   = ($urandom_range(9) != 0);
    end
    ena = 1'b1; ack_i = 1'b0; btn_raw = 1'b0;
    wait_ticks(10);
    pulse_ack();
    wait_ticks(4);

    // saturation
    for (int p = 0; p < 300; p++) begin
      btn_raw = 1'b1; wait_ticks(7);
      pulse_ack();
      btn_raw = 1'b0; wait_ticks(7);
    end
    check("sat_cnt", int'(press_cnt_o), 255);

    // async reset in the middle of a request
    btn_raw = 1'b1; wait_ticks(8);
    check("pre_reset_req", int'(req_o), 1);
    rst_n = 1'b0; #1;
    check("async_req", int'(req_o), 0);
    check("async_cnt", int'(press_cnt_o), 0);
    check("async_clean", int'(btn_clean_o), 0);
    btn_raw = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
